lsu_wb: RTL and testbench
=========================

Name: lsu_wb

Overview:
- Memory-access/writeback stage of the riscx pipeline and the write side of the register file: it drives the regfile's rd_en/rd_idx/rd_wdata port.
- Accepts one retiring op per handshake from the execute stage and performs at most one load or store on a valid/ready data-memory port.
- Aligns and extends load data, then issues exactly one regfile write per op that has a destination.
- Holds off the execute stage while a memory access is outstanding.

Parameters:
XLEN, 32, data/address width (`XLEN)
REG_IDX_WIDTH, 5, register index width (`REG_IDX_WIDTH)

Ports:
clk  input  1  clock
rst_n  input  1  reset, asynchronous, active-low
ex_valid_i  input  1  execute stage presents an op
ex_ready_o  output  1  stage can accept an op this cycle
ex_rd_en_i  input  1  op writes rd
ex_rd_idx_i  input  REG_IDX_WIDTH  destination index
ex_result_i  input  XLEN  ALU result, or effective address for load/store
ex_mem_rd_i  input  1  op is a load
ex_mem_wr_i  input  1  op is a store
ex_funct3_i  input  3  access size/sign (RV32I load/store funct3)
ex_store_data_i  input  XLEN  rs2 data for stores
mem_req_valid_o  output  1  memory request valid
mem_req_ready_i  input  1  memory accepts request
mem_req_we_o  output  1  1 = write
mem_req_addr_o  output  XLEN  word-aligned address (low 2 bits zero)
mem_req_wdata_o  output  XLEN  lane-shifted store data
mem_req_wstrb_o  output  XLEN/8  byte enables
mem_rsp_valid_i  input  1  load data returned (reads only)
mem_rsp_rdata_i  input  XLEN  full word read
wb_rd_en_o  output  1  regfile write enable
wb_rd_idx_o  output  REG_IDX_WIDTH  regfile write index
wb_rd_wdata_o  output  XLEN  regfile write data
lsu_err_o  output  1  one-cycle pulse: misaligned access or illegal funct3

Behaviour:
- Clock, reset and timing:
  - Clock is clk. Reset rst_n is asynchronous, active-low.
  - All outputs are registered except ex_ready_o, which is (state==IDLE).
  - Reset values: every output 0, state IDLE.
- States: IDLE, REQ, RESP.
- Accept: the handshake ex_valid_i & ex_ready_o in cycle T captures all ex_* inputs.
- Non-memory op:
  - Stays in IDLE.
  - wb_rd_en_o = ex_rd_en_i & (idx!=0) in T+1, with idx and ex_result_i; single-cycle pulse.
- Memory op (load or store):
  - Go to REQ.
  - mem_req_valid_o rises in T+1 and is held stable, with all req fields constant, until sampled with mem_req_ready_i=1.
- Request completion (from REQ):
  - Store: complete on handshake, return to IDLE. No regfile write, no response expected.
  - Load: on handshake go to RESP, deassert mem_req_valid_o.
- Load response (in RESP):
  - On mem_rsp_valid_i, extract the lane by addr[1:0] and size. LB/LH sign-extend; LBU/LHU zero-extend; LW passes through.
  - Write to wb_* in the next cycle (suppressed if rd_en=0 or idx=0), return to IDLE.
  - mem_rsp_valid_i outside RESP is ignored.
- Stores:
  - SB: wdata = byte replicated to all lanes, wstrb = 1<<addr[1:0].
  - SH: halfword replicated to both halves, wstrb = 0011/1100 by addr[1].
  - SW: wstrb = 1111.
- Errors:
  - Error conditions: halfword with addr[0]=1; word with addr[1:0]!=0; ex_mem_rd_i & ex_mem_wr_i both set; funct3 outside {0,1,2,4,5} for loads or {0,1,2} for stores.
  - On error: lsu_err_o pulses in T+1, no memory request, no writeback, stay in IDLE.
- Back-to-back: a new op may be accepted in the cycle the FSM returns to IDLE's combinational ready, i.e. the cycle after completion. A non-memory op every cycle sustains throughput 1.
- Reset mid-operation: state → IDLE, mem_req_valid_o and wb_rd_en_o clear immediately (asynchronous). The in-flight op is dropped; a late mem_rsp_valid_i is ignored.
- Ordering: exactly one wb write per accepted op with a nonzero destination; never two ops in flight.

Decomposition:
- Shared package/defines.v:
  - XLEN, REG_IDX_WIDTH.
  - funct3 encodings LB/LH/LW/LBU/LHU/SB/SH/SW.
  - FSM state localparams.
- One sub-module lsu_align: combinational store lane shift/wstrb generation and load extract/extend, plus misalignment check. Reused by any future cache path.

Test Plan:
- ALU op, rd=x5, result 0x1234_5678 → wb_rd_en_o=1, idx=5, wdata 0x12345678 in next cycle; ex_ready_o stays 1; rd=x0 → wb_rd_en_o stays 0.
- LW addr 0x100, mem_req_ready_i delayed 2 cycles, rsp after 3 more → req fields stable while waiting, ex_ready_o=0 throughout, wb wdata = rdata one cycle after rsp.
- LB addr 0x203, rdata 0x80FF_1234 → wdata 0xFFFF_FF80; LBU same → 0x0000_0080; LHU addr 0x202 → 0x0000_80FF.
- SH addr 0x42, data 0x0000_ABCD → addr 0x40, wdata 0xABCD_ABCD, wstrb 1100, we=1; no wb write; back to IDLE after ready.
- LW addr 0x102 → lsu_err_o one-cycle pulse, mem_req_valid_o never asserts, no wb write.
- Assert rst_n low while in RESP, then release; apply stray mem_rsp_valid_i → all outputs 0, state IDLE, no wb write.

Source files
------------

// File: rtl/lsu_wb_pkg.sv
// Shared widths, RV32I load/store funct3 encodings, FSM states and request struct
// for the riscx memory-access/writeback stage.
package lsu_wb_pkg;
  localparam int XLEN          = 32;
  localparam int REG_IDX_WIDTH = 5;
  localparam int NUM_LANES     = XLEN / 8;

  localparam logic [2:0] LB  = 3'd0;
  localparam logic [2:0] LH  = 3'd1;
  localparam logic [2:0] LW  = 3'd2;
  localparam logic [2:0] LBU = 3'd4;
  localparam logic [2:0] LHU = 3'd5;
  localparam logic [2:0] SB  = 3'd0;
  localparam logic [2:0] SH  = 3'd1;
  localparam logic [2:0] SW  = 3'd2;

  typedef enum logic [1:0] {S_IDLE, S_REQ, S_RESP} state_e;

  typedef struct packed {
    logic                 we;
    logic [XLEN-1:0]      addr;
    logic [XLEN-1:0]      wdata;
    logic [NUM_LANES-1:0] wstrb;
  } mem_req_t;

  // Load bookkeeping kept while the access is outstanding
  typedef struct packed {
    logic                     rd_en;
    logic [REG_IDX_WIDTH-1:0] rd_idx;
    logic [2:0]               f3;
    logic [1:0]               off;
  } ld_op_t;
endpackage

// File: rtl/lsu_wb_if.sv
// Data-memory request/response port: master side is the LSU, slave side the memory.
interface lsu_wb_if;
  import lsu_wb_pkg::*;
  logic                 req_valid;
  logic                 req_ready;
  logic                 req_we;
  logic [XLEN-1:0]      req_addr;
  logic [XLEN-1:0]      req_wdata;
  logic [NUM_LANES-1:0] req_wstrb;
  logic                 rsp_valid;
  logic [XLEN-1:0]      rsp_rdata;

  modport master (output req_valid, req_we, req_addr, req_wdata, req_wstrb,
                  input  req_ready, rsp_valid, rsp_rdata);
  modport slave  (input  req_valid, req_we, req_addr, req_wdata, req_wstrb,
                  output req_ready, rsp_valid, rsp_rdata);
endinterface

// File: rtl/lsu_align.sv
// Combinational byte-lane logic: store replicate/strobe, load extract/extend,
// and access legality (size alignment, funct3, load+store conflict).
module lsu_align
  import lsu_wb_pkg::*;
(
  input  logic                 is_ld_i,
  input  logic                 is_st_i,
  input  logic [2:0]           acc_f3_i,
  input  logic [1:0]           acc_off_i,
  input  logic [XLEN-1:0]      st_data_i,
  output logic [XLEN-1:0]      st_wdata_o,
  output logic [NUM_LANES-1:0] st_wstrb_o,
  output logic                 err_o,
  input  logic [2:0]           ld_f3_i,
  input  logic [1:0]           ld_off_i,
  input  logic [XLEN-1:0]      ld_rdata_i,
  output logic [XLEN-1:0]      ld_data_o
);
  logic            misalign, ld_ok, st_ok;
  logic [XLEN-1:0] sh;

  always_comb begin
    misalign = (acc_f3_i[1:0] == 2'd1 && acc_off_i[0]) ||
               (acc_f3_i[1:0] == 2'd2 && acc_off_i != 2'd0);
    ld_ok    = acc_f3_i inside {LB, LH, LW, LBU, LHU};
    st_ok    = acc_f3_i inside {SB, SH, SW};
    err_o    = (is_ld_i & is_st_i) |
               (is_ld_i & (~ld_ok | misalign)) |
               (is_st_i & (~st_ok | misalign));

    case (acc_f3_i[1:0])
      2'd0: begin
        st_wdata_o = {NUM_LANES{st_data_i[7:0]}};
        st_wstrb_o = NUM_LANES'(1) << acc_off_i;
      end
      2'd1: begin
        st_wdata_o = {(NUM_LANES/2){st_data_i[15:0]}};
        st_wstrb_o = NUM_LANES'(4'b0011) << {acc_off_i[1], 1'b0};
      end
      default: begin
        st_wdata_o = st_data_i;
        st_wstrb_o = '1;
      end
    endcase

    sh = ld_rdata_i >> {ld_off_i, 3'b000};
    case (ld_f3_i)
      LB:      ld_data_o = {{(XLEN-8){sh[7]}}, sh[7:0]};
      LH:      ld_data_o = {{(XLEN-16){sh[15]}}, sh[15:0]};
      LBU:     ld_data_o = {{(XLEN-8){1'b0}}, sh[7:0]};
      LHU:     ld_data_o = {{(XLEN-16){1'b0}}, sh[15:0]};
      default: ld_data_o = ld_rdata_i;
    endcase
  end
endmodule

// File: rtl/lsu_wb.sv
// Memory-access/writeback stage: one op per handshake, at most one memory access,
// exactly one regfile write per op with a nonzero destination.
module lsu_wb
  import lsu_wb_pkg::*;
(
  input  logic                     clk,
  input  logic                     rst_n,
  input  logic                     ex_valid_i,
  output logic                     ex_ready_o,
  input  logic                     ex_rd_en_i,
  input  logic [REG_IDX_WIDTH-1:0] ex_rd_idx_i,
  input  logic [XLEN-1:0]          ex_result_i,
  input  logic                     ex_mem_rd_i,
  input  logic                     ex_mem_wr_i,
  input  logic [2:0]               ex_funct3_i,
  input  logic [XLEN-1:0]          ex_store_data_i,
  lsu_wb_if.master                 mem,
  output logic                     wb_rd_en_o,
  output logic [REG_IDX_WIDTH-1:0] wb_rd_idx_o,
  output logic [XLEN-1:0]          wb_rd_wdata_o,
  output logic                     lsu_err_o
);
  state_e                   state_q, state_d;
  mem_req_t                 req_q, req_d;
  logic                     req_valid_q, req_valid_d;
  ld_op_t                   op_q, op_d;
  logic                     wb_en_q, wb_en_d, err_q, err_d;
  logic [REG_IDX_WIDTH-1:0] wb_idx_q, wb_idx_d;
  logic [XLEN-1:0]          wb_data_q, wb_data_d;
  logic [XLEN-1:0]          st_wdata, ld_data;
  logic [NUM_LANES-1:0]     st_wstrb;
  logic                     acc_err;

  lsu_align u_align (
    .is_ld_i   (ex_mem_rd_i),
    .is_st_i   (ex_mem_wr_i),
    .acc_f3_i  (ex_funct3_i),
    .acc_off_i (ex_result_i[1:0]),
    .st_data_i (ex_store_data_i),
    .st_wdata_o(st_wdata),
    .st_wstrb_o(st_wstrb),
    .err_o     (acc_err),
    .ld_f3_i   (op_q.f3),
    .ld_off_i  (op_q.off),
    .ld_rdata_i(mem.rsp_rdata),
    .ld_data_o (ld_data)
  );

  always_comb begin
    state_d     = state_q;
    req_d       = req_q;
    req_valid_d = req_valid_q;
    op_d        = op_q;
    wb_en_d     = 1'b0;
    wb_idx_d    = wb_idx_q;
    wb_data_d   = wb_data_q;
    err_d       = 1'b0;
    case (state_q)
      S_IDLE: if (ex_valid_i) begin
        if (ex_mem_rd_i | ex_mem_wr_i) begin
          if (acc_err) begin
            err_d = 1'b1;
          end else begin
            state_d     = S_REQ;
            req_valid_d = 1'b1;
            // Loads carry no write payload on the bus
            req_d = '{we:    ex_mem_wr_i,
                      addr:  {ex_result_i[XLEN-1:2], 2'b00},
                      wdata: ex_mem_wr_i ? st_wdata : '0,
                      wstrb: ex_mem_wr_i ? st_wstrb : '0};
            op_d  = '{rd_en: ex_rd_en_i, rd_idx: ex_rd_idx_i,
                      f3: ex_funct3_i, off: ex_result_i[1:0]};
          end
        end else begin
          wb_en_d   = ex_rd_en_i && (ex_rd_idx_i != '0);
          wb_idx_d  = ex_rd_idx_i;
          wb_data_d = ex_result_i;
        end
      end
      S_REQ: if (mem.req_ready) begin
        req_valid_d = 1'b0;
        state_d     = req_q.we ? S_IDLE : S_RESP;
      end
      S_RESP: if (mem.rsp_valid) begin
        wb_en_d   = op_q.rd_en && (op_q.rd_idx != '0);
        wb_idx_d  = op_q.rd_idx;
        wb_data_d = ld_data;
        state_d   = S_IDLE;
      end
      default: state_d = S_IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q     <= S_IDLE;
      req_q       <= '0;
      req_valid_q <= 1'b0;
      op_q        <= '0;
      wb_en_q     <= 1'b0;
      wb_idx_q    <= '0;
      wb_data_q   <= '0;
      err_q       <= 1'b0;
    end else begin
      state_q     <= state_d;
      req_q       <= req_d;
      req_valid_q <= req_valid_d;
      op_q        <= op_d;
      wb_en_q     <= wb_en_d;
      wb_idx_q    <= wb_idx_d;
      wb_data_q   <= wb_data_d;
      err_q       <= err_d;
    end
  end

  assign ex_ready_o    = (state_q == S_IDLE);
  assign mem.req_valid = req_valid_q;
  assign mem.req_we    = req_q.we;
  assign mem.req_addr  = req_q.addr;
  assign mem.req_wdata = req_q.wdata;
  assign mem.req_wstrb = req_q.wstrb;
  assign wb_rd_en_o    = wb_en_q;
  assign wb_rd_idx_o   = wb_idx_q;
  assign wb_rd_wdata_o = wb_data_q;
  assign lsu_err_o     = err_q;
endmodule

// File: tb/tb_lsu_wb.sv
// Directed bench for lsu_wb: a spec-level model sets per-cycle expectations that a
// negedge compare process checks; literal checks pin the model itself.
module tb_lsu_wb;
  import lsu_wb_pkg::*;

  logic        clk = 1'b0, rst_n = 1'b0;
  logic        ex_valid_i = 0, ex_rd_en_i = 0, ex_mem_rd_i = 0, ex_mem_wr_i = 0;
  logic [4:0]  ex_rd_idx_i = 0;
  logic [31:0] ex_result_i = 0, ex_store_data_i = 0;
  logic [2:0]  ex_funct3_i = 0;
  logic        ex_ready_o, wb_rd_en_o, lsu_err_o;
  logic [4:0]  wb_rd_idx_o;
  logic [31:0] wb_rd_wdata_o;

  lsu_wb_if mif();

  lsu_wb dut (
    .clk(clk), .rst_n(rst_n),
    .ex_valid_i(ex_valid_i), .ex_ready_o(ex_ready_o), .ex_rd_en_i(ex_rd_en_i),
    .ex_rd_idx_i(ex_rd_idx_i), .ex_result_i(ex_result_i), .ex_mem_rd_i(ex_mem_rd_i),
    .ex_mem_wr_i(ex_mem_wr_i), .ex_funct3_i(ex_funct3_i), .ex_store_data_i(ex_store_data_i),
    .mem(mif.master),
    .wb_rd_en_o(wb_rd_en_o), .wb_rd_idx_o(wb_rd_idx_o), .wb_rd_wdata_o(wb_rd_wdata_o),
    .lsu_err_o(lsu_err_o)
  );

  always #5 clk = ~clk;

  int checks = 0, failures = 0;
  bit chk_on = 0;
  bit exp_busy = 0, exp_wb_v = 0, exp_err = 0, exp_req_v = 0, exp_we = 0;
  logic [4:0]  exp_idx = 0;
  logic [31:0] exp_wdata = 0, exp_addr = 0, exp_mwdata = 0;
  logic [3:0]  exp_strb = 0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s actual=%h expected=%h at %0t", name, act, exp, $time);
    end
  endtask

  // Spec-level model of the lane rules
  function automatic logic [31:0] m_load(input logic [2:0] f3, input logic [31:0] addr,
                                         input logic [31:0] rdata);
    int unsigned off = addr % 4;
    logic [31:0] b = (rdata >> (8 * off)) % 256;
    logic [31:0] h = (rdata >> (8 * off)) % 65536;
    case (f3)
      3'd0:    return (b >= 128) ? (b | 32'hFFFF_FF00) : b;
      3'd1:    return (h >= 32768) ? (h | 32'hFFFF_0000) : h;
      3'd4:    return b;
      3'd5:    return h;
      default: return rdata;
    endcase
  endfunction

  function automatic logic [31:0] m_wdata(input logic [2:0] f3, input logic [31:0] d);
    if (f3 == 3'd0) return (d % 256) * 32'h0101_0101;
    if (f3 == 3'd1) return (d % 65536) * 32'h0001_0001;
    return d;
  endfunction

  function automatic logic [3:0] m_wstrb(input logic [2:0] f3, input logic [31:0] addr);
    if (f3 == 3'd0) return 4'(1 << (addr % 4));
    if (f3 == 3'd1) return ((addr % 4) >= 2) ? 4'b1100 : 4'b0011;
    return 4'b1111;
  endfunction

  function automatic bit m_err(input bit rd, input bit wr, input logic [2:0] f3,
                               input logic [31:0] addr);
    if (rd && wr) return 1;
    if (rd && !(f3 == 0 || f3 == 1 || f3 == 2 || f3 == 4 || f3 == 5)) return 1;
    if (wr && !(f3 == 0 || f3 == 1 || f3 == 2)) return 1;
    if ((f3 == 1 || f3 == 5) && (addr % 2) != 0) return 1;
    if (f3 == 2 && (addr % 4) != 0) return 1;
    return 0;
  endfunction

  always @(negedge clk) if (chk_on) begin
    chk("ex_ready", 32'(ex_ready_o), 32'(!exp_busy));
    chk("wb_en", 32'(wb_rd_en_o), 32'(exp_wb_v));
    if (exp_wb_v) begin
      chk("wb_idx", 32'(wb_rd_idx_o), 32'(exp_idx));
      chk("wb_data", wb_rd_wdata_o, exp_wdata);
    end
    chk("lsu_err", 32'(lsu_err_o), 32'(exp_err));
    chk("req_valid", 32'(mif.req_valid), 32'(exp_req_v));
    if (exp_req_v) begin
      chk("req_we", 32'(mif.req_we), 32'(exp_we));
      chk("req_addr", mif.req_addr, exp_addr);
      if (exp_we) begin
        chk("req_wdata", mif.req_wdata, exp_mwdata);
        chk("req_wstrb", 32'(mif.req_wstrb), 32'(exp_strb));
      end
    end
  end

  task automatic tick();
    @(posedge clk); #1;
    exp_wb_v = 0;
    exp_err  = 0;
  endtask

  task automatic drive(input bit rd_en, input logic [4:0] idx, input logic [31:0] res,
                       input bit mrd, input bit mwr, input logic [2:0] f3,
                       input logic [31:0] sdata);
    ex_valid_i = 1; ex_rd_en_i = rd_en; ex_rd_idx_i = idx; ex_result_i = res;
    ex_mem_rd_i = mrd; ex_mem_wr_i = mwr; ex_funct3_i = f3; ex_store_data_i = sdata;
  endtask

  task automatic do_op(input bit rd_en, input logic [4:0] idx, input logic [31:0] res,
                       input bit mrd, input bit mwr, input logic [2:0] f3,
                       input logic [31:0] sdata, input int req_lat, input int rsp_lat,
                       input logic [31:0] rdata);
    drive(rd_en, idx, res, mrd, mwr, f3, sdata);
    tick();
    ex_valid_i = 0;
    if (!(mrd || mwr)) begin
      exp_wb_v = rd_en && idx != 0; exp_idx = idx; exp_wdata = res;
    end else if (m_err(mrd, mwr, f3, res)) begin
      exp_err = 1;
    end else begin
      exp_busy = 1; exp_req_v = 1; exp_we = mwr; exp_addr = res & ~32'h3;
      exp_mwdata = m_wdata(f3, sdata); exp_strb = m_wstrb(f3, res);
      repeat (req_lat) tick();
      mif.req_ready = 1;
      tick();
      mif.req_ready = 0;
      exp_req_v = 0;
      if (mwr) exp_busy = 0;
      else begin
        repeat (rsp_lat) tick();
        mif.rsp_valid = 1; mif.rsp_rdata = rdata;
        tick();
        mif.rsp_valid = 0;
        exp_busy = 0;
        exp_wb_v = rd_en && idx != 0; exp_idx = idx; exp_wdata = m_load(f3, res, rdata);
      end
    end
  endtask

  initial begin
    mif.req_ready = 0; mif.rsp_valid = 0; mif.rsp_rdata = 0;

    chk("model_lb",  m_load(LB,  32'h203, 32'h80FF_1234), 32'hFFFF_FF80);
    chk("model_lbu", m_load(LBU, 32'h203, 32'h80FF_1234), 32'h0000_0080);
    chk("model_lhu", m_load(LHU, 32'h202, 32'h80FF_1234), 32'h0000_80FF);
    chk("model_sh_wdata", m_wdata(SH, 32'h0000_ABCD), 32'hABCD_ABCD);
    chk("model_sh_wstrb", 32'(m_wstrb(SH, 32'h42)), 32'hC);
    chk("model_sb_wstrb", 32'(m_wstrb(SB, 32'h101)), 32'h2);
    chk("model_err_lw102", 32'(m_err(1, 0, LW, 32'h102)), 32'h1);

    #12;
    chk("rst_ready", 32'(ex_ready_o), 32'h1);
    chk("rst_req_valid", 32'(mif.req_valid), 32'h0);
    chk("rst_req_we", 32'(mif.req_we), 32'h0);
    chk("rst_req_addr", mif.req_addr, 32'h0);
    chk("rst_req_wdata", mif.req_wdata, 32'h0);
    chk("rst_req_wstrb", 32'(mif.req_wstrb), 32'h0);
    chk("rst_wb_en", 32'(wb_rd_en_o), 32'h0);
    chk("rst_wb_idx", 32'(wb_rd_idx_o), 32'h0);
    chk("rst_wb_data", wb_rd_wdata_o, 32'h0);
    chk("rst_err", 32'(lsu_err_o), 32'h0);
    @(posedge clk); #1;
    rst_n = 1; chk_on = 1;

    // ALU ops back to back, incl. x0 and rd_en=0
    do_op(1, 5'd5, 32'h1234_5678, 0, 0, 3'd0, 0, 0, 0, 0);
    chk("alu_wb_data_lit", wb_rd_wdata_o, 32'h1234_5678);
    do_op(1, 5'd0, 32'hFFFF_FFFF, 0, 0, 3'd0, 0, 0, 0, 0);
    do_op(0, 5'd7, 32'h0BAD_0BAD, 0, 0, 3'd0, 0, 0, 0, 0);
    do_op(1, 5'd31, 32'hCAFE_F00D, 0, 0, 3'd0, 0, 0, 0, 0);

    // Loads
    do_op(1, 5'd10, 32'h100, 1, 0, LW, 0, 2, 3, 32'hDEAD_BEEF);
    chk("lw_wb_data_lit", wb_rd_wdata_o, 32'hDEAD_BEEF);
    do_op(1, 5'd11, 32'h203, 1, 0, LB,  0, 0, 0, 32'h80FF_1234);
    chk("lb_wb_data_lit", wb_rd_wdata_o, 32'hFFFF_FF80);
    do_op(1, 5'd12, 32'h203, 1, 0, LBU, 0, 1, 1, 32'h80FF_1234);
    do_op(1, 5'd13, 32'h202, 1, 0, LHU, 0, 0, 2, 32'h80FF_1234);
    do_op(1, 5'd14, 32'h202, 1, 0, LH,  0, 0, 0, 32'h80FF_1234);
    do_op(1, 5'd15, 32'h200, 1, 0, LH,  0, 0, 0, 32'h80FF_1234);
    do_op(1, 5'd16, 32'h201, 1, 0, LB,  0, 0, 0, 32'h80FF_7F34);
    do_op(1, 5'd0,  32'h300, 1, 0, LW,  0, 0, 1, 32'h5555_AAAA);
    do_op(0, 5'd17, 32'h304, 1, 0, LW,  0, 0, 0, 32'h1111_2222);

    // Stores
    do_op(0, 5'd0, 32'h42,  0, 1, SH, 32'h0000_ABCD, 1, 0, 0);
    do_op(1, 5'd9, 32'h101, 0, 1, SB, 32'h1234_565A, 0, 0, 0);
    do_op(0, 5'd0, 32'h200, 0, 1, SW, 32'hA5A5_0F0F, 3, 0, 0);
    do_op(0, 5'd0, 32'h40,  0, 1, SH, 32'h9999_1357, 0, 0, 0);

    // Errors
    do_op(1, 5'd3, 32'h102, 1, 0, LW,   0, 0, 0, 0);
    tick();
    do_op(1, 5'd3, 32'h41,  0, 1, SH,   32'h1, 0, 0, 0);
    do_op(1, 5'd3, 32'h40,  1, 0, 3'd3, 0, 0, 0, 0);
    do_op(0, 5'd0, 32'h40,  0, 1, 3'd4, 32'h1, 0, 0, 0);
    do_op(1, 5'd3, 32'h40,  1, 1, LW,   0, 0, 0, 0);
    do_op(1, 5'd4, 32'h201, 1, 0, LHU,  0, 0, 0, 0);
    do_op(1, 5'd6, 32'h7777_0001, 0, 0, 3'd0, 0, 0, 0, 0);

    // Stray response in IDLE must be ignored
    mif.rsp_valid = 1; mif.rsp_rdata = 32'hFEED_FACE;
    tick();
    mif.rsp_valid = 0;
    tick();

    // Reset while waiting in RESP
    drive(1, 5'd9, 32'h300, 1, 0, LW, 0);
    tick();
    ex_valid_i = 0;
    exp_busy = 1; exp_req_v = 1; exp_we = 0; exp_addr = 32'h300;
    mif.req_ready = 1;
    tick();
    mif.req_ready = 0; exp_req_v = 0;
    tick();
    exp_busy = 0;
    rst_n = 0;
    #1;
    chk("mid_rst_req_valid", 32'(mif.req_valid), 32'h0);
    chk("mid_rst_wb_en", 32'(wb_rd_en_o), 32'h0);
    chk("mid_rst_ready", 32'(ex_ready_o), 32'h1);
    tick();
    rst_n = 1;
    mif.rsp_valid = 1; mif.rsp_rdata = 32'h1357_9BDF;
    tick();
    mif.rsp_valid = 0;
    tick();
    chk("post_rst_wb_data", wb_rd_wdata_o, 32'h0);

    do_op(1, 5'd8, 32'h0000_0042, 0, 0, 3'd0, 0, 0, 0, 0);
    repeat (3) tick();
    chk_on = 0;
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
